// File: rtl/fast_cmd_tx_pkg.sv
// fast_cmd_tx_pkg: fast-command symbol codes and frame width shared by the fast-command transmitter.
package fast_cmd_tx_pkg;
  localparam int FRAME_W = 8;
  typedef logic [FRAME_W-1:0] fcCode_t;
  localparam fcCode_t FC_IDLE = 8'hF0;
  localparam fcCode_t FC_BCR = 8'h5A;
  localparam fcCode_t FC_L1A = 8'h96;
  localparam fcCode_t FC_LINK_RESET = 8'h33;
endpackage

// File: rtl/fast_cmd_tx_fifo.sv
// fc_cmd_fifo: 2-entry command queue; a write while full is taken only together with a read.
module fc_cmd_fifo import fast_cmd_tx_pkg::*; (
  input  logic    clock,
  input  logic    reset,
  input  logic    write,
  input  fcCode_t writeData,
  input  logic    read,
  output fcCode_t readData,
  output logic    empty,
  output logic    full
);
  fcCode_t mem [2];
  logic wrPtr, rdPtr, doWrite, doRead;
  logic [1:0] count;
  always_comb begin
    empty = count == 2'd0;
    full = count == 2'd2;
    doWrite = write && (!full || read);
    doRead = read && !empty;
    readData = mem[rdPtr];
  end
  always_ff @(posedge clock)
    if (doWrite) mem[wrPtr] <= writeData;
  always_ff @(posedge clock)
    if (reset) begin
      wrPtr <= 1'b0;
      rdPtr <= 1'b0;
      count <= 2'd0;
    end else begin
      if (doWrite) wrPtr <= !wrPtr;
      if (doRead) rdPtr <= !rdPtr;
      count <= count + {1'b0, doWrite} - {1'b0, doRead};
    end
endmodule

// File: rtl/fast_cmd_tx.sv
// fast_cmd_tx: 8-bit fast-command serializer with a 2-deep queue and frame-aligned output delay.
// Define AUTO_BCR_EN to insert BCR_CODE once per ORBIT_LEN frames.
module fast_cmd_tx import fast_cmd_tx_pkg::*; #(
  parameter fcCode_t IDLE_CODE = FC_IDLE,
  parameter fcCode_t BCR_CODE = FC_BCR,
  parameter int ORBIT_LEN = 3564
) (
  input  logic       clk320,
  input  logic       reset,
  input  logic       cmdValid,
  input  fcCode_t    cmdCode,
  output logic       cmdReady,
  input  logic [2:0] bitDelay,
  output logic       fcOut,
  output logic       frameStart,
  output logic       cmdSent
);
  logic [2:0] bitCnt, activeDelay;
  fcCode_t shiftReg, headCode, loadCode;
  logic [6:0] delayLine;
  logic [7:0] tapVec;
  logic boundary, fifoEmpty, fifoFull, bcrSlot, pop;
  fc_cmd_fifo u_fifo (
    .clock(clk320),
    .reset(reset),
    .write(cmdValid && cmdReady),
    .writeData(cmdCode),
    .read(pop),
    .readData(headCode),
    .empty(fifoEmpty),
    .full(fifoFull)
  );
`ifdef AUTO_BCR_EN
  localparam int OW = ORBIT_LEN > 1 ? $clog2(ORBIT_LEN) : 1;
  logic [OW-1:0] orbitCnt;
  assign bcrSlot = orbitCnt == OW'(ORBIT_LEN - 1);
  always_ff @(posedge clk320)
    if (reset) orbitCnt <= '0;
    else if (bitCnt == 3'd7) orbitCnt <= bcrSlot ? '0 : orbitCnt + 1'b1;
`else
  assign bcrSlot = 1'b0;
`endif
  always_comb begin
    boundary = bitCnt == 3'd7;
    pop = boundary && !fifoEmpty && !bcrSlot;
    loadCode = bcrSlot ? BCR_CODE : fifoEmpty ? IDLE_CODE : headCode;
    cmdReady = !fifoFull;
    cmdSent = pop;
    tapVec = {delayLine, shiftReg[7]};
  end
  // The tap is registered into fcOut, so a delay captured at a boundary first
  // affects the bit after the old frame's last undelayed bit.
  always_ff @(posedge clk320)
    if (reset) begin
      bitCnt <= 3'd0;
      shiftReg <= IDLE_CODE;
      delayLine <= '0;
      activeDelay <= 3'd0;
      fcOut <= 1'b0;
      frameStart <= 1'b0;
    end else begin
      bitCnt <= bitCnt + 3'd1;
      shiftReg <= boundary ? loadCode : {shiftReg[6:0], 1'b0};
      delayLine <= {delayLine[5:0], shiftReg[7]};
      fcOut <= tapVec[activeDelay];
      if (boundary) activeDelay <= bitDelay;
      frameStart <= boundary;
    end
endmodule

// File: tb/tb_fast_cmd_tx.sv
// tb_fast_cmd_tx: directed checks of fast_cmd_tx framing, queueing, delay and reset behaviour.
module tb_fast_cmd_tx;
  logic clk320 = 1'b0;
  logic reset = 1'b1;
  logic cmdValid = 1'b0;
  logic [7:0] cmdCode = 8'h00;
  logic [2:0] bitDelay = 3'd0;
  logic cmdReady, fcOut, frameStart, cmdSent;
  int checks = 0;
  int errors = 0;
  int sentCnt = 0;
  int accCnt = 0;
  int s;
  logic [7:0] f;

  fast_cmd_tx #(.ORBIT_LEN(4)) dut (
    .clk320(clk320),
    .reset(reset),
    .cmdValid(cmdValid),
    .cmdCode(cmdCode),
    .cmdReady(cmdReady),
    .bitDelay(bitDelay),
    .fcOut(fcOut),
    .frameStart(frameStart),
    .cmdSent(cmdSent)
  );

  always #5 clk320 = ~clk320;

  always @(posedge clk320) begin
    if (!reset && cmdSent === 1'b1) sentCnt <= sentCnt + 1;
    if (!reset && cmdValid && cmdReady === 1'b1) accCnt <= accCnt + 1;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk320);
  endtask

  task automatic frame(input string tag, input int skip, input logic [7:0] exp);
    logic [7:0] b;
    cyc(skip);
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk320);
      b[i] = fcOut;
    end
    check(tag, b, exp);
  endtask

  task automatic waitFs(input string tag, input int expGap);
    int n = 0;
    while (frameStart !== 1'b1 && n < 20) begin
      @(negedge clk320);
      n++;
    end
    check(tag, 8'(n), 8'(expGap));
  endtask

  initial begin
    cyc(3);
    check("rst_ready", cmdReady, 1);
    check("rst_fcout", fcOut, 0);
    check("rst_fs", frameStart, 0);
    check("rst_sent", cmdSent, 0);
`ifdef AUTO_BCR_EN
    cmdValid = 1'b1;
    cmdCode = 8'h96;
    reset = 1'b0;
    waitFs("first_load", 8);
    for (int k = 0; k < 8; k++)
      if (k % 4 == 3) frame("bcr_frame", 0, 8'h5A);
      else frame("l1a_frame", 0, 8'h96);
    check("bcr_sent", 8'(sentCnt), 8'd6);
    check("bcr_no_loss", 8'(accCnt - sentCnt), 8'd2);
    check("bcr_full", cmdReady, 0);
    cmdValid = 1'b0;
`else
    reset = 1'b0;
    waitFs("first_load", 8);
    frame("idle0", 0, 8'hF0);
    waitFs("fs_period", 0);
    frame("idle1", 0, 8'hF0);
    // single command offered at bitCnt=2
    s = sentCnt;
    cyc(2);
    cmdValid = 1'b1;
    cmdCode = 8'h96;
    check("ready_single", cmdReady, 1);
    cyc(1);
    cmdValid = 1'b0;
    cyc(4);
    check("sent_pulse", cmdSent, 1);
    waitFs("fs_single", 1);
    frame("single", 0, 8'h96);
    frame("after_single", 0, 8'hF0);
    check("sent_once", 8'(sentCnt - s), 8'd1);
    // back-pressure: three offers on consecutive cycles from bitCnt=1
    s = sentCnt;
    cyc(1);
    cmdValid = 1'b1;
    cmdCode = 8'h96;
    check("ready_bp0", cmdReady, 1);
    cyc(1);
    cmdCode = 8'h33;
    check("ready_bp1", cmdReady, 1);
    cyc(1);
    cmdCode = 8'h5A;
    check("ready_full", cmdReady, 0);
    cyc(4);
    check("ready_at_pop", cmdReady, 0);
    check("sent_bp", cmdSent, 1);
    cyc(1);
    check("ready_after_pop", cmdReady, 1);
    check("fs_bp", frameStart, 1);
    frame("bp_96", 0, 8'h96);
    cmdValid = 1'b0;
    frame("bp_33", 0, 8'h33);
    frame("bp_5a", 0, 8'h5A);
    frame("bp_idle", 0, 8'hF0);
    check("sent_bp_total", 8'(sentCnt - s), 8'd3);
    // write into empty FIFO in the boundary cycle waits one frame
    cyc(7);
    cmdValid = 1'b1;
    cmdCode = 8'h33;
    check("sent_boundary", cmdSent, 0);
    cyc(1);
    cmdValid = 1'b0;
    frame("boundary_idle", 0, 8'hF0);
    frame("boundary_cmd", 0, 8'h33);
    // delay 0 -> 3 changed mid-frame while a command is queued
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk320);
      f[i] = fcOut;
      if (i == 7) begin
        cmdValid = 1'b1;
        cmdCode = 8'h96;
      end
      if (i == 6) cmdValid = 1'b0;
      if (i == 5) bitDelay = 3'd3;
    end
    check("delay_inflight", f, 8'hF0);
    check("fs_delay", frameStart, 1);
    frame("delay3", 3, 8'h96);
    bitDelay = 3'd0;
    waitFs("fs_delay_back", 5);
    frame("delay0", 0, 8'hF0);
    // reset at bitCnt=4 of a 96 frame with 33 still queued
    s = sentCnt;
    cyc(1);
    cmdValid = 1'b1;
    cmdCode = 8'h96;
    cyc(1);
    cmdCode = 8'h33;
    cyc(1);
    cmdValid = 1'b0;
    waitFs("fs_rst_cmd", 5);
    cyc(4);
    reset = 1'b1;
    cyc(1);
    check("rst_mid_fcout", fcOut, 0);
    check("rst_mid_ready", cmdReady, 1);
    check("rst_mid_sent", cmdSent, 0);
    cyc(1);
    check("rst_mid_fcout2", fcOut, 0);
    check("rst_mid_fs", frameStart, 0);
    reset = 1'b0;
    waitFs("fs_after_rst", 8);
    frame("post_rst0", 0, 8'hF0);
    frame("post_rst1", 0, 8'hF0);
    check("rst_sent_count", 8'(sentCnt - s), 8'd1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fast_cmd_tx.md
FAST_CMD_TX -- requirements
Module: fast_cmd_tx

Interface
REQ-001 Parameter IDLE_CODE, default 8'hF0, the symbol sent in any frame with no queued command.
REQ-002 Parameter BCR_CODE, default 8'h5A, the bunch-counter-reset symbol used by the auto-BCR feature.
REQ-003 Parameter ORBIT_LEN, default 3564, the number of frames per orbit, used only when AUTO_BCR_EN is defined.
REQ-004 clk320  input  1  320 MHz bit clock; every register is clocked on the rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 cmdValid  input  1  command offer from the upstream source.
REQ-007 cmdCode  input  8  command symbol, sampled when cmdValid and cmdReady are both high.
REQ-008 cmdReady  output  1  the queue can accept a command.
REQ-009 bitDelay  input  3  output phase shift, in whole bit periods (0..7).
REQ-010 fcOut  output  1  serial fast-command stream, MSB first, one 8-bit frame per 8 clk320 cycles.
REQ-011 frameStart  output  1  one-cycle pulse in the cycle in which bit 7 of a new frame, before any delay, is driven.
REQ-012 cmdSent  output  1  one-cycle pulse when a queued command is loaded into the serializer.

Function
REQ-013 The block SHALL hold a 3-bit bit counter bitCnt that increments every cycle and wraps from 7 to 0.
- A frame boundary occurs at bitCnt==7.
REQ-014 The block SHALL queue commands in a 2-entry FIFO.
- cmdReady = !full.
- A write occurs when cmdValid && cmdReady.
- cmdValid while full is not accepted and has no effect.
REQ-015 At each frame boundary, the shift register SHALL load the FIFO head if the FIFO is non-empty, and IDLE_CODE otherwise.
- When the head is loaded, the FIFO pops and cmdSent pulses in the same cycle.
REQ-016 A simultaneous write and pop at a frame boundary SHALL be legal when the FIFO is full.
- Occupancy is unchanged.
- cmdReady is driven from the registered state and stays low during that cycle.
REQ-017 A write into an empty FIFO in the boundary cycle itself SHALL NOT be sent in that frame; it is sent in the next frame.
REQ-018 The shift register SHALL shift left one bit per cycle.
- The undelayed serial bit is the shift register MSB.
REQ-019 fcOut SHALL be the undelayed bit passed through an 8-stage delay line.
- The tap is selected by the active delay value: tap 0 = undelayed, registered once.
REQ-020 Fixed latency from a load to the first fcOut bit SHALL be 1 + active delay cycles.
REQ-021 The active delay SHALL capture bitDelay only at frame boundaries.
- A bitDelay change mid-frame never corrupts the frame in flight.
- Bits may be repeated or dropped only across the boundary at which the delay changes.
REQ-022 frameStart SHALL assert in the cycle after each load, i.e. one pulse every 8 cycles.

Reset
REQ-023 While reset is high, the block SHALL drive these values:
- bitCnt=0, FIFO empty, cmdReady=1.
- Shift register = IDLE_CODE, delay line all 0.
- Active delay = 0, fcOut=0, frameStart=0, cmdSent=0.
REQ-024 After reset is released, the first load SHALL occur 7 cycles later, at bitCnt==7.
REQ-025 Reset asserted mid-frame SHALL discard the frame in flight and all queued commands in the next cycle.
- No partial frame is resumed.

Configuration
REQ-026 When macro AUTO_BCR_EN is defined, the block SHALL keep an orbit frame counter 0..ORBIT_LEN-1 that increments at each load.
- At the boundary where the counter wraps to 0, BCR_CODE is loaded instead of the FIFO head.
- In that frame the FIFO does not pop and cmdSent stays low.
REQ-027 When AUTO_BCR_EN is undefined, the block SHALL contain no orbit counter logic and SHALL never insert BCR_CODE by itself.

Structure
REQ-028 A shared package SHALL hold the fast-command code constants (IDLE 8'hF0, BCR 8'h5A, L1A 8'h96, LinkReset 8'h33) and the frame width constant 8.
REQ-029 The 2-entry FIFO SHALL be one sub-module, fc_cmd_fifo.
- Its ports are clock, reset, write, writeData, read, readData, empty and full.

Verification
REQ-030 Idle run: after reset with no cmdValid, fcOut SHALL repeat 11110000, with frameStart every 8 cycles.
REQ-031 Single command: cmdCode=8'h96 accepted at bitCnt=2 -> the next frame carries 10010110, cmdSent pulses once, and the following frame is IDLE.
REQ-032 Back-pressure: present 8'h96, 8'h33 and 8'h5A on consecutive cycles ->
- cmdReady drops after two writes.
- The third is accepted after the first pop.
- The frames are sent in order 96, 33, 5A.
REQ-033 Delay: change bitDelay 0->3 mid-frame -> the current frame is unchanged, and the next frame's MSB appears 3 cycles later than with delay 0.
REQ-034 Reset mid-command: reset at bitCnt=4 during an 8'h96 frame, with one command queued ->
- fcOut=0 in the next cycle.
- After release, only IDLE frames are sent.
REQ-035 With AUTO_BCR_EN and ORBIT_LEN=4, and the FIFO kept full of 8'h96 -> every 4th frame is 01011010, and no command is lost.
